// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, latency counter width, byte lanes, trace format.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int LAT_CNT_W = 4;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = 4;

  localparam string TRACE_FMT = "@%h: *%h <= %h";

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge: lanes with be set take wdata,
// the rest keep the old word.
module dm_byte_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // Overlay enabled lanes onto the old word
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Define DM_TRACE_EN to print a line per committed store.
module dm_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        req_ready,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [LAT_CNT_W-1:0] CNT_INIT =
    LAT_CNT_W'(LATENCY - 1);

  dm_state_e state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic        addr_err;
  logic        commit;
  logic [31:0] rd_word;
  logic [31:0] merged;

  assign idx      = addr_q[ADDR_W+1:2];
  assign addr_err = (|addr_q[1:0]) || (|addr_q[31:ADDR_W+2]);
  assign rd_word  = mem_q[idx];

  dm_byte_merge u_merge (
    .old_word (rd_word),
    .wdata    (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;

  // Next state, request latch, and access result
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    commit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          be_d    = be;
          wdata_d = wdata;
          pc_d    = pc;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          err_d        = addr_err;
          rdata_d      = (addr_err || we_q) ? '0 : rd_word;
          commit       = we_q && !addr_err;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage array; a store commits on the WAIT->RESP edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[idx] <= merged;
`ifdef DM_TRACE_EN
      if (|be_q) begin
        $display(TRACE_FMT, pc_q, {addr_q[31:2], 2'b00}, merged);
      end
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule
